fetch_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage.
- Owns the PC and issues req/ack fetches to instruction memory.
- Presents instruction and next PC to decode; decode's next_pc input is fed from this block's next_pc_o.
- Handles hazard stalls with a 1-entry skid buffer, jump redirects with squash, and end-of-program halt.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_skid_buffer.sv | 38 +++
 rtl/fetch_stage.sv | 171 +++++++++++++++++
 tb/tb_fetch_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM state, IF/ID record, bubble encoding.
package fetch_pkg;

    localparam int unsigned FETCH_PC_W    = 16;
    localparam int unsigned FETCH_INSTR_W = 16;
    localparam logic [FETCH_INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_PC_W-1:0]    pc;
        logic [FETCH_PC_W-1:0]    next_pc;
        logic                     valid;
    } ifid_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an IF/ID record captured while decode is stalled.
module fetch_skid_buffer
    import fetch_pkg::*;
#(
    parameter type entry_t = ifid_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load_i,
    input  entry_t data_i,
    input  logic   pop_i,
    input  logic   clear_i,
    output logic   full_o,
    output entry_t data_o
);

    entry_t data_q;
    logic   full_q;

    // clear beats load: a redirect or halt must never leave stale data behind
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            data_q <= data_i;
            full_q <= 1'b1;
        end else if (pop_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register with skid buffer, redirect squash and halt.
// Optional `FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
//   state | meaning
//   FETCH | PC owned here, requests issued whenever the skid buffer is empty
//   HALT  | end of program; no requests, bubbles only, left only by reset
module fetch_stage #(
    parameter int unsigned             PC_BITS    = 16,
    parameter int unsigned             INSTR_SIZE = 16,
    parameter int unsigned             JUMP_BITS  = 10,
    parameter logic [PC_BITS-1:0]      RESET_PC   = '0,
    parameter logic [INSTR_SIZE-1:0]   NOP_INSTR  = INSTR_SIZE'(fetch_pkg::NOP_INSTR)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_o,
    output logic [PC_BITS-1:0]    imem_addr_o,
    input  logic                  imem_valid_i,
    input  logic [INSTR_SIZE-1:0] imem_rdata_i,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [JUMP_BITS-1:0]  redirect_addr_i,
    input  logic                  halt_i,
    output logic [INSTR_SIZE-1:0] instruction_o,
    output logic [PC_BITS-1:0]    pc_o,
    output logic [PC_BITS-1:0]    next_pc_o,
    output logic                  valid_o,
    output logic                  halted_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           fetch_count_o,
    output logic [31:0]           stall_count_o
`endif
);
    import fetch_pkg::*;

    typedef struct packed {
        logic [INSTR_SIZE-1:0] instr;
        logic [PC_BITS-1:0]    pc;
        logic [PC_BITS-1:0]    next_pc;
        logic                  valid;
    } ifid_w_t;

    fetch_state_t       state_q;
    logic [PC_BITS-1:0] pc_q;
    logic [PC_BITS-1:0] tgt_q;
    logic               drop_q;
    ifid_w_t            ifid_q;

    logic               skid_full;
    ifid_w_t            skid_data;
    logic               skid_load;
    logic               skid_pop;
    logic               skid_clear;

    logic [PC_BITS-1:0] pc_inc;
    logic [PC_BITS-1:0] redir_pc;
    logic               accept;
    logic               take;
    logic               normal;
    ifid_w_t            fetched;
    ifid_w_t            bubble;

    assign pc_inc   = pc_q + 1'b1;
    assign redir_pc = PC_BITS'(redirect_addr_i);

    assign imem_req_o  = rst && (state_q == FETCH) && !skid_full;
    assign imem_addr_o = pc_q;

    // an ack while drop_q is set belongs to a squashed request
    assign accept = imem_req_o && imem_valid_i;
    assign take   = accept && !drop_q;
    assign normal = (state_q == FETCH) && !halt_i && !redirect_i;

    assign fetched = '{instr: imem_rdata_i, pc: pc_q, next_pc: pc_inc, valid: 1'b1};
    assign bubble  = '{instr: NOP_INSTR, pc: '0, next_pc: '0, valid: 1'b0};

    assign skid_load  = normal && stall_i && take;
    assign skid_pop   = normal && !stall_i && skid_full;
    assign skid_clear = (state_q == FETCH) && (halt_i || redirect_i);

    fetch_skid_buffer #(
        .entry_t (ifid_w_t)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .data_i  (fetched),
        .pop_i   (skid_pop),
        .clear_i (skid_clear),
        .full_o  (skid_full),
        .data_o  (skid_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            drop_q  <= 1'b0;
            ifid_q  <= bubble;
        end else begin
            case (state_q)
                FETCH: begin
                    if (halt_i) begin
                        state_q <= HALT;
                        drop_q  <= 1'b0;
                        ifid_q  <= bubble;
                    end else if (redirect_i) begin
                        ifid_q <= bubble;
                        // keep the address stable until the in-flight request is acked
                        if (imem_req_o && !imem_valid_i) begin
                            drop_q <= 1'b1;
                            tgt_q  <= redir_pc;
                        end else begin
                            drop_q <= 1'b0;
                            pc_q   <= redir_pc;
                        end
                    end else begin
                        if (accept && drop_q) begin
                            drop_q <= 1'b0;
                            pc_q   <= tgt_q;
                        end else if (take) begin
                            pc_q <= pc_inc;
                        end
                        if (!stall_i) begin
                            if (skid_full)
                                ifid_q <= skid_data;
                            else if (take)
                                ifid_q <= fetched;
                            else
                                ifid_q <= bubble;
                        end
                    end
                end
                HALT: begin
                    ifid_q <= bubble;
                end
            endcase
        end
    end

    assign instruction_o = ifid_q.instr;
    assign pc_o          = ifid_q.pc;
    assign next_pc_o     = ifid_q.next_pc;
    assign valid_o       = ifid_q.valid;
    assign halted_o      = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        ifid_wr_valid;

    assign ifid_wr_valid = normal && !stall_i && (skid_full || take);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (ifid_wr_valid && (fetch_cnt_q != 32'hFFFF_FFFF))
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_i && (state_q == FETCH) && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_count_o = fetch_cnt_q;
    assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle vector table plus wrap, halt and reset sequences.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall, redirect, halt, ack_auto, ack_man;
    logic [9:0]  raddr;

    logic        req, valid, halted, imem_valid;
    logic [15:0] addr, rdata, instr, pc, npc;

    logic        req2, valid2, halted2;
    logic [15:0] addr2, rdata2, instr2, pc2, npc2;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fcnt, scnt, fcnt2, scnt2;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign imem_valid = ack_auto ? req : ack_man;
    assign rdata      = 16'h1000 + addr;
    assign rdata2     = 16'h1000 + addr2;

    fetch_stage u_dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_o      (req),
        .imem_addr_o     (addr),
        .imem_valid_i    (imem_valid),
        .imem_rdata_i    (rdata),
        .stall_i         (stall),
        .redirect_i      (redirect),
        .redirect_addr_i (raddr),
        .halt_i          (halt),
        .instruction_o   (instr),
        .pc_o            (pc),
        .next_pc_o       (npc),
        .valid_o         (valid),
        .halted_o        (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count_o   (fcnt),
        .stall_count_o   (scnt)
`endif
    );

    fetch_stage #(.RESET_PC(16'hFFFF)) u_wrap (
        .clk             (clk),
        .rst             (rst),
        .imem_req_o      (req2),
        .imem_addr_o     (addr2),
        .imem_valid_i    (req2),
        .imem_rdata_i    (rdata2),
        .stall_i         (1'b0),
        .redirect_i      (1'b0),
        .redirect_addr_i (10'd0),
        .halt_i          (1'b0),
        .instruction_o   (instr2),
        .pc_o            (pc2),
        .next_pc_o       (npc2),
        .valid_o         (valid2),
        .halted_o        (halted2)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count_o   (fcnt2),
        .stall_count_o   (scnt2)
`endif
    );

    typedef struct {
        logic        stall, redir;
        logic [9:0]  raddr;
        logic        halt, auto, ack;
        logic        ev;
        logic [15:0] ei, epc, enpc;
        logic        ereq;
        logic [15:0] eaddr;
        logic        eh, caddr;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic s, logic r, logic [9:0] ra, logic h, logic au, logic ak,
                                logic ev, logic [15:0] ei, logic [15:0] epc, logic [15:0] enpc,
                                logic erq, logic [15:0] ea, logic eh, logic ca);
        vec_t v;
        v.stall = s;   v.redir = r;  v.raddr = ra; v.halt = h; v.auto = au; v.ack = ak;
        v.ev    = ev;  v.ei    = ei; v.epc   = epc; v.enpc = enpc;
        v.ereq  = erq; v.eaddr = ea; v.eh    = eh;  v.caddr = ca;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        stall = 0; redirect = 0; halt = 0; raddr = '0; ack_auto = 1; ack_man = 0;

        //            st rd raddr   hl au ak  ev instr     pc       npc      req addr     h  ca
        vecs[0]  = mk(0, 0, 10'h0,  0, 1, 0,  1, 16'h1000, 16'h0,   16'h1,   1, 16'h1,   0, 1);
        vecs[1]  = mk(0, 0, 10'h0,  0, 1, 0,  1, 16'h1001, 16'h1,   16'h2,   1, 16'h2,   0, 1);
        vecs[2]  = mk(0, 0, 10'h0,  0, 1, 0,  1, 16'h1002, 16'h2,   16'h3,   1, 16'h3,   0, 1);
        vecs[3]  = mk(0, 0, 10'h0,  0, 1, 0,  1, 16'h1003, 16'h3,   16'h4,   1, 16'h4,   0, 1);
        vecs[4]  = mk(1, 0, 10'h0,  0, 1, 0,  1, 16'h1003, 16'h3,   16'h4,   0, 16'h5,   0, 1);
        vecs[5]  = mk(1, 0, 10'h0,  0, 1, 0,  1, 16'h1003, 16'h3,   16'h4,   0, 16'h5,   0, 1);
        vecs[6]  = mk(1, 0, 10'h0,  0, 1, 0,  1, 16'h1003, 16'h3,   16'h4,   0, 16'h5,   0, 1);
        vecs[7]  = mk(0, 0, 10'h0,  0, 1, 0,  1, 16'h1004, 16'h4,   16'h5,   1, 16'h5,   0, 1);
        vecs[8]  = mk(0, 0, 10'h0,  0, 1, 0,  1, 16'h1005, 16'h5,   16'h6,   1, 16'h6,   0, 1);
        vecs[9]  = mk(0, 0, 10'h0,  0, 1, 0,  1, 16'h1006, 16'h6,   16'h7,   1, 16'h7,   0, 1);
        vecs[10] = mk(0, 0, 10'h0,  0, 0, 0,  0, 16'h0,    16'h0,   16'h0,   1, 16'h7,   0, 1);
        vecs[11] = mk(0, 1, 10'h3FF,0, 0, 0,  0, 16'h0,    16'h0,   16'h0,   1, 16'h7,   0, 1);
        vecs[12] = mk(0, 0, 10'h0,  0, 0, 0,  0, 16'h0,    16'h0,   16'h0,   1, 16'h7,   0, 1);
        vecs[13] = mk(0, 0, 10'h0,  0, 0, 1,  0, 16'h0,    16'h0,   16'h0,   1, 16'h3FF, 0, 1);
        vecs[14] = mk(0, 0, 10'h0,  0, 0, 1,  1, 16'h13FF, 16'h3FF, 16'h400, 1, 16'h400, 0, 1);
        vecs[15] = mk(0, 0, 10'h0,  0, 1, 0,  1, 16'h1400, 16'h400, 16'h401, 1, 16'h401, 0, 1);
        vecs[16] = mk(1, 1, 10'h20, 0, 1, 0,  0, 16'h0,    16'h0,   16'h0,   1, 16'h20,  0, 1);
        vecs[17] = mk(1, 0, 10'h0,  0, 1, 0,  0, 16'h0,    16'h0,   16'h0,   0, 16'h21,  0, 1);
        vecs[18] = mk(0, 0, 10'h0,  0, 1, 0,  1, 16'h1020, 16'h20,  16'h21,  1, 16'h21,  0, 1);
        vecs[19] = mk(0, 0, 10'h0,  0, 1, 0,  1, 16'h1021, 16'h21,  16'h22,  1, 16'h22,  0, 1);
        vecs[20] = mk(0, 1, 10'h5,  1, 1, 0,  0, 16'h0,    16'h0,   16'h0,   0, 16'h0,   1, 0);
        vecs[21] = mk(0, 0, 10'h0,  0, 1, 0,  0, 16'h0,    16'h0,   16'h0,   0, 16'h0,   1, 0);

        #1;
        chk("reset instr",  {16'h0, instr}, 32'h0);
        chk("reset pc",     {16'h0, pc},    32'h0);
        chk("reset npc",    {16'h0, npc},   32'h0);
        chk("reset valid",  {31'h0, valid}, 32'h0);
        chk("reset req",    {31'h0, req},   32'h0);
        chk("reset halted", {31'h0, halted},32'h0);
        tick();
        tick();
        rst = 1'b1;

        for (int i = 0; i < 22; i++) begin
            stall    = vecs[i].stall;
            redirect = vecs[i].redir;
            raddr    = vecs[i].raddr;
            halt     = vecs[i].halt;
            ack_auto = vecs[i].auto;
            ack_man  = vecs[i].ack;
            tick();
            chk($sformatf("v%0d valid", i), {31'h0, valid},  {31'h0, vecs[i].ev});
            chk($sformatf("v%0d instr", i), {16'h0, instr},  {16'h0, vecs[i].ei});
            chk($sformatf("v%0d pc", i),    {16'h0, pc},     {16'h0, vecs[i].epc});
            chk($sformatf("v%0d npc", i),   {16'h0, npc},    {16'h0, vecs[i].enpc});
            chk($sformatf("v%0d req", i),   {31'h0, req},    {31'h0, vecs[i].ereq});
            chk($sformatf("v%0d halted", i),{31'h0, halted}, {31'h0, vecs[i].eh});
            if (vecs[i].caddr)
                chk($sformatf("v%0d addr", i), {16'h0, addr}, {16'h0, vecs[i].eaddr});
            if (i == 0) begin
                chk("wrap pc",    {16'h0, pc2},    32'hFFFF);
                chk("wrap npc",   {16'h0, npc2},   32'h0);
                chk("wrap instr", {16'h0, instr2}, 32'h0FFF);
                chk("wrap addr",  {16'h0, addr2},  32'h0);
                chk("wrap valid", {31'h0, valid2}, 32'h1);
            end
            if (i == 1) begin
                chk("wrap2 pc",    {16'h0, pc2},    32'h0);
                chk("wrap2 npc",   {16'h0, npc2},   32'h1);
                chk("wrap2 instr", {16'h0, instr2}, 32'h1000);
            end
`ifdef FETCH_PERF_CNT_EN
            if (i == 7) begin
                chk("perf fetch", fcnt, 32'd5);
                chk("perf stall", scnt, 32'd3);
            end
`endif
        end

        for (int c = 0; c < 20; c++) begin
            stall    = 1'($urandom_range(0, 1));
            redirect = 1'($urandom_range(0, 1));
            raddr    = 10'($urandom_range(0, 1023));
            halt     = 1'b0;
            tick();
            chk($sformatf("halt%0d valid", c),  {31'h0, valid},  32'h0);
            chk($sformatf("halt%0d req", c),    {31'h0, req},    32'h0);
            chk($sformatf("halt%0d halted", c), {31'h0, halted}, 32'h1);
        end

        stall = 0; redirect = 0; raddr = '0; ack_auto = 1;
        rst = 1'b0;
        #1;
        chk("async rst halted", {31'h0, halted}, 32'h0);
        chk("async rst valid",  {31'h0, valid},  32'h0);
        chk("async rst req",    {31'h0, req},    32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("async rst fetch cnt", fcnt, 32'h0);
        chk("async rst stall cnt", scnt, 32'h0);
`endif
        #1;
        rst = 1'b1;
        tick();
        chk("restart instr",  {16'h0, instr},  32'h1000);
        chk("restart pc",     {16'h0, pc},     32'h0);
        chk("restart valid",  {31'h0, valid},  32'h1);
        chk("restart halted", {31'h0, halted}, 32'h0);
        chk("restart addr",   {16'h0, addr},   32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
